// File: rtl/rank_pipe_feeder_pkg.sv
// Shared types, rank-op codes and saturating arithmetic for the rank pipe feeder.
package rank_pipe_feeder_pkg;

    localparam int RPF_RANK_WIDTH = 16;
    localparam int RPF_LEN_WIDTH  = 16;
    localparam int RPF_SIZE_WIDTH = 32;

    localparam int OP_SRPT = 0;
    localparam int OP_FIFO = 1;
    localparam int OP_EDF  = 2;
    localparam int OP_PASS = 3;

    typedef struct packed {
        logic                      valid;
        logic [RPF_SIZE_WIDTH-1:0] remaining;
    } flow_entry_t;

    // Bytes left after a packet; overshooting the flow size just drains it to zero.
    function automatic logic [RPF_SIZE_WIDTH-1:0] sat_sub(
        input logic [RPF_SIZE_WIDTH-1:0] a,
        input logic [RPF_LEN_WIDTH-1:0]  b
    );
        logic [RPF_SIZE_WIDTH-1:0] b_ext;
        b_ext = {{(RPF_SIZE_WIDTH-RPF_LEN_WIDTH){1'b0}}, b};
        return (a > b_ext) ? (a - b_ext) : '0;
    endfunction

    function automatic logic [RPF_RANK_WIDTH-1:0] sat_rank(
        input logic [RPF_SIZE_WIDTH-1:0] a
    );
        if (a[RPF_SIZE_WIDTH-1:RPF_RANK_WIDTH] != '0)
            return '1;
        return a[RPF_RANK_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rank_pipe_feeder_srpt_flow_table.sv
// Per-flow remaining-bytes table: flop array, combinational read, single write port.
module srpt_flow_table
    import rank_pipe_feeder_pkg::*;
#(
    parameter int FLOW_ID_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FLOW_ID_WIDTH-1:0] rd_id,
    output flow_entry_t              rd_entry,
    input  logic                     wr_en,
    input  logic [FLOW_ID_WIDTH-1:0] wr_id,
    input  flow_entry_t              wr_entry
);

    localparam int ENTRIES = 1 << FLOW_ID_WIDTH;

    flow_entry_t entries_q [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                entries_q[i] <= '0;
        end else if (wr_en) begin
            entries_q[wr_id] <= wr_entry;
        end
    end

    assign rd_entry = entries_q[rd_id];

endmodule

// File: rtl/rank_pipe_feeder.sv
// Producer front end for the rank pipe: computes SRPT ranks from per-flow state
// and issues one insert per accepted descriptor through a single holding register.
module rank_pipe_feeder
    import rank_pipe_feeder_pkg::*;
#(
    parameter int RANK_CODE_BITS = 2,
    parameter int RANK_WIDTH     = RPF_RANK_WIDTH,
    parameter int META_WIDTH     = 16,
    parameter int SRPT_OP        = OP_SRPT,
    parameter int FLOW_ID_WIDTH  = 4,
    parameter int LEN_WIDTH      = RPF_LEN_WIDTH,
    parameter int SIZE_WIDTH     = RPF_SIZE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      s_first,
    input  logic [FLOW_ID_WIDTH-1:0]  s_flow_id,
    input  logic [LEN_WIDTH-1:0]      s_pkt_len,
    input  logic [SIZE_WIDTH-1:0]     s_flow_size,
    input  logic [RANK_CODE_BITS-1:0] s_rank_op,
    input  logic [META_WIDTH-1:0]     s_meta,
    input  logic                      busy,
    output logic                      insert,
    output logic [RANK_CODE_BITS-1:0] rank_op_out,
    output logic [META_WIDTH-1:0]     meta_out,
    output logic [RANK_WIDTH-1:0]     srpt_rank_out,
    output logic                      err_unknown_flow,
    output logic [31:0]               insert_count
);

    logic                  out_valid;
    logic                  accept;
    logic                  is_srpt;
    logic                  unknown_flow;
    logic                  wr_en;
    flow_entry_t           rd_entry;
    flow_entry_t           wr_entry;
    logic [SIZE_WIDTH-1:0] rem_before;
    logic [SIZE_WIDTH-1:0] rem_after;
    logic [RANK_WIDTH-1:0] rank_next;

    assign insert  = out_valid & ~busy;
    assign s_ready = ~out_valid | ~busy;
    assign accept  = s_valid & s_ready;
    assign is_srpt = (s_rank_op == RANK_CODE_BITS'(SRPT_OP));

    srpt_flow_table #(
        .FLOW_ID_WIDTH(FLOW_ID_WIDTH)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_id   (s_flow_id),
        .rd_entry(rd_entry),
        .wr_en   (wr_en),
        .wr_id   (s_flow_id),
        .wr_entry(wr_entry)
    );

    // A non-first packet on an invalid entry gets the worst rank and leaves the table alone.
    always_comb begin
        rem_before   = s_first ? s_flow_size : rd_entry.remaining;
        unknown_flow = is_srpt & ~s_first & ~rd_entry.valid;
        rem_after    = sat_sub(rem_before, s_pkt_len);
        rank_next    = '0;
        if (is_srpt)
            rank_next = unknown_flow ? '1 : sat_rank(rem_before);
        wr_en              = accept & is_srpt & ~unknown_flow;
        wr_entry.valid     = (rem_after != '0);
        wr_entry.remaining = rem_after;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            rank_op_out      <= '0;
            meta_out         <= '0;
            srpt_rank_out    <= '0;
            err_unknown_flow <= 1'b0;
            insert_count     <= '0;
        end else begin
            if (accept) begin
                out_valid     <= 1'b1;
                rank_op_out   <= s_rank_op;
                meta_out      <= s_meta;
                srpt_rank_out <= rank_next;
            end else if (insert) begin
                out_valid <= 1'b0;
            end
            err_unknown_flow <= accept & unknown_flow;
            if (insert)
                insert_count <= insert_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_rank_pipe_feeder.sv
// Directed vector bench for rank_pipe_feeder with a small SRPT reference model for streaming.
module tb_rank_pipe_feeder;

    typedef struct {
        logic        first;
        logic [3:0]  flow_id;
        logic [15:0] pkt_len;
        logic [31:0] flow_size;
        logic [1:0]  rank_op;
        logic [15:0] meta;
        logic [15:0] exp_rank;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_first = 1'b0;
    logic [3:0]  s_flow_id = '0;
    logic [15:0] s_pkt_len = '0;
    logic [31:0] s_flow_size = '0;
    logic [1:0]  s_rank_op = '0;
    logic [15:0] s_meta = '0;
    logic        busy = 1'b0;
    logic        insert;
    logic [1:0]  rank_op_out;
    logic [15:0] meta_out;
    logic [15:0] srpt_rank_out;
    logic        err_unknown_flow;
    logic [31:0] insert_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rank_pipe_feeder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_first         (s_first),
        .s_flow_id       (s_flow_id),
        .s_pkt_len       (s_pkt_len),
        .s_flow_size     (s_flow_size),
        .s_rank_op       (s_rank_op),
        .s_meta          (s_meta),
        .busy            (busy),
        .insert          (insert),
        .rank_op_out     (rank_op_out),
        .meta_out        (meta_out),
        .srpt_rank_out   (srpt_rank_out),
        .err_unknown_flow(err_unknown_flow),
        .insert_count    (insert_count)
    );

    function automatic vec_t mk(input logic first, input logic [3:0] id, input logic [15:0] len,
                                input logic [31:0] size, input logic [1:0] op, input logic [15:0] meta,
                                input logic [15:0] rank, input logic err);
        vec_t v;
        v.first = first; v.flow_id = id; v.pkt_len = len; v.flow_size = size;
        v.rank_op = op; v.meta = meta; v.exp_rank = rank; v.exp_err = err;
        return v;
    endfunction

    // Drive one cycle's inputs on the falling edge and let combinational outputs settle.
    task automatic applyStimulus(input logic valid, input vec_t d, input logic busy_v);
        @(negedge clk);
        s_valid     = valid;
        s_first     = d.first;
        s_flow_id   = d.flow_id;
        s_pkt_len   = d.pkt_len;
        s_flow_size = d.flow_size;
        s_rank_op   = d.rank_op;
        s_meta      = d.meta;
        busy        = busy_v;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        busy    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs [14];
    vec_t idle;
    vec_t a_desc, b_desc, d_desc;

    logic        m_valid [16];
    logic [31:0] m_rem   [16];
    logic [15:0] exp_q [$];

    initial begin
        vecs[0]  = mk(1, 3, 1500, 4000,   0, 16'h0001, 4000,  0);
        vecs[1]  = mk(0, 3, 1500, 0,      0, 16'h0002, 2500,  0);
        vecs[2]  = mk(0, 3, 1500, 0,      0, 16'h0003, 1000,  0);
        vecs[3]  = mk(0, 3, 10,   0,      0, 16'h0004, 16'hFFFF, 1);
        vecs[4]  = mk(1, 5, 1000, 100000, 0, 16'h0005, 16'hFFFF, 0);
        vecs[5]  = mk(0, 5, 40000, 0,     0, 16'h0006, 16'hFFFF, 0);
        vecs[6]  = mk(0, 5, 40000, 0,     0, 16'h0007, 59000, 0);
        vecs[7]  = mk(0, 7, 1,    0,      0, 16'h0008, 16'hFFFF, 1);
        vecs[8]  = mk(0, 5, 500,  0,      1, 16'hBEEF, 0,     0);
        vecs[9]  = mk(0, 5, 20000, 0,     0, 16'h0009, 19000, 0);
        vecs[10] = mk(1, 7, 10,   50,     1, 16'h000A, 0,     0);
        vecs[11] = mk(0, 7, 10,   0,      0, 16'h000B, 16'hFFFF, 1);
        vecs[12] = mk(1, 2, 50,   10,     0, 16'h000C, 10,    0);
        vecs[13] = mk(0, 2, 1,    0,      0, 16'h000D, 16'hFFFF, 1);
        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0);
        a_desc   = mk(1, 9,  100, 300, 0, 16'h000A, 300, 0);
        b_desc   = mk(1, 10, 100, 700, 0, 16'h000B, 700, 0);
        d_desc   = mk(1, 11, 100, 500, 0, 16'h000D, 500, 0);

        // Reset held with a valid descriptor present
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, vecs[0], 0);
            checkOutput("rst_insert", insert, 0);
            checkOutput("rst_ready", s_ready, 1);
            checkOutput("rst_count", insert_count, 0);
        end
        applyStimulus(0, idle, 0);
        rst_n = 1'b1;
        checkOutput("rel_insert", insert, 0);
        checkOutput("rel_rank", srpt_rank_out, 0);
        checkOutput("rel_meta", meta_out, 0);
        checkOutput("rel_op", rank_op_out, 0);
        checkOutput("rel_err", err_unknown_flow, 0);
        applyStimulus(0, idle, 0);
        checkOutput("rel_insert2", insert, 0);

        // Table-driven single descriptors, busy low
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, vecs[i], 0);
            checkOutput("vec_ready", s_ready, 1);
            checkOutput("vec_idle_insert", insert, 0);
            checkOutput("vec_err_pulse_end", err_unknown_flow, 0);
            applyStimulus(0, idle, 0);
            checkOutput("vec_insert", insert, 1);
            checkOutput("vec_rank", srpt_rank_out, vecs[i].exp_rank);
            checkOutput("vec_meta", meta_out, vecs[i].meta);
            checkOutput("vec_op", rank_op_out, vecs[i].rank_op);
            checkOutput("vec_err", err_unknown_flow, vecs[i].exp_err);
        end
        applyStimulus(0, idle, 0);
        checkOutput("vec_count", insert_count, 14);

        // Backpressure: A held under busy, then drains while B is accepted
        applyStimulus(1, a_desc, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, b_desc, 1);
            checkOutput("bp_insert", insert, 0);
            checkOutput("bp_ready", s_ready, 0);
            checkOutput("bp_rank", srpt_rank_out, 300);
            checkOutput("bp_meta", meta_out, 16'h000A);
        end
        applyStimulus(1, b_desc, 0);
        checkOutput("bp_drain_insert", insert, 1);
        checkOutput("bp_drain_ready", s_ready, 1);
        checkOutput("bp_drain_rank", srpt_rank_out, 300);
        applyStimulus(0, idle, 0);
        checkOutput("bp_b_insert", insert, 1);
        checkOutput("bp_b_rank", srpt_rank_out, 700);
        checkOutput("bp_b_meta", meta_out, 16'h000B);
        applyStimulus(0, idle, 0);
        checkOutput("bp_empty", insert, 0);
        checkOutput("bp_count", insert_count, 16);

        // Reset while a descriptor is held: it is dropped and the table cleared
        applyStimulus(1, d_desc, 1);
        applyStimulus(0, idle, 1);
        checkOutput("mid_held", insert, 0);
        rst_n = 1'b0;
        applyStimulus(0, idle, 0);
        checkOutput("mid_rst_insert", insert, 0);
        rst_n = 1'b1;
        applyStimulus(0, idle, 0);
        checkOutput("mid_rel_insert", insert, 0);
        checkOutput("mid_rel_ready", s_ready, 1);
        checkOutput("mid_rel_count", insert_count, 0);
        applyStimulus(1, mk(0, 10, 1, 0, 0, 16'h0010, 0, 0), 0);
        applyStimulus(0, idle, 0);
        checkOutput("mid_flow10_rank", srpt_rank_out, 16'hFFFF);
        checkOutput("mid_flow10_err", err_unknown_flow, 1);

        // Streaming with random busy against the reference model
        resetDut();
        for (int f = 0; f < 16; f++) begin
            m_valid[f] = 1'b0;
            m_rem[f]   = '0;
        end
        begin
            int   sent = 0;
            int   got = 0;
            int   cycles = 0;
            int   f;
            vec_t cur;
            logic [31:0] rb, ra;
            cur = idle;
            cur.flow_id   = 0;
            cur.first     = 1;
            cur.pkt_len   = 16'($urandom_range(100, 1500));
            cur.flow_size = $urandom_range(2000, 8000);
            while ((got < 64 || sent < 64) && cycles < 2000) begin
                applyStimulus(sent < 64, cur, ($urandom_range(0, 2) == 0));
                checkOutput("stream_no_insert_busy", {31'd0, insert & busy}, 0);
                if (insert) begin
                    if (exp_q.size() == 0)
                        checkOutput("stream_spurious_insert", 1, 0);
                    else
                        checkOutput("stream_rank", srpt_rank_out, exp_q.pop_front());
                    got++;
                end
                if (s_valid && s_ready) begin
                    f  = int'(cur.flow_id);
                    rb = cur.first ? cur.flow_size : m_rem[f];
                    exp_q.push_back((rb > 32'd65535) ? 16'hFFFF : rb[15:0]);
                    ra = (rb > {16'd0, cur.pkt_len}) ? rb - {16'd0, cur.pkt_len} : 32'd0;
                    m_rem[f]   = ra;
                    m_valid[f] = (ra != 0);
                    sent++;
                    if (sent < 64) begin
                        cur.flow_id   = 4'(sent % 4);
                        cur.first     = !m_valid[sent % 4];
                        cur.pkt_len   = 16'($urandom_range(100, 1500));
                        cur.flow_size = $urandom_range(2000, 8000);
                        cur.meta      = 16'(sent);
                    end
                end
                cycles++;
            end
            checkOutput("stream_inserts", got, 64);
            checkOutput("stream_accepts", sent, 64);
        end
        applyStimulus(0, idle, 0);
        checkOutput("stream_count", insert_count, 64);
        checkOutput("stream_drained", insert, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rank_pipe_feeder.md
Name: rank_pipe_feeder

Overview:
Producer-side front end for the rank pipe. It accepts per-packet descriptors on a valid/ready stream and computes an SRPT rank from a per-flow remaining-size table. It then issues exactly one insert per descriptor on the rank pipe's insert/busy interface. It sits between the parser-metadata path and the rank pipe, and owns all flow state the rank pipe does not keep.

Parameters:
RANK_CODE_BITS, 2, width of rank-op code.
RANK_WIDTH, 16, width of srpt rank.
META_WIDTH, 16, opaque metadata width.
SRPT_OP, 0, rank-op code that selects SRPT computation.
FLOW_ID_WIDTH, 4, log2 of flow-table entries (16 flows).
LEN_WIDTH, 16, packet length width (bytes).
SIZE_WIDTH, 32, flow size / remaining-bytes width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  descriptor valid
s_ready  out  1  descriptor accepted when s_valid & s_ready
s_first  in  1  first packet of flow; loads s_flow_size
s_flow_id  in  FLOW_ID_WIDTH  flow index
s_pkt_len  in  LEN_WIDTH  packet bytes
s_flow_size  in  SIZE_WIDTH  total flow bytes (sampled only when s_first)
s_rank_op  in  RANK_CODE_BITS  rank op
s_meta  in  META_WIDTH  opaque metadata
busy  in  1  rank-pipe busy; insert forbidden while 1
insert  out  1  rank-pipe insert strobe
rank_op_out  out  RANK_CODE_BITS  to rank pipe
meta_out  out  META_WIDTH  to rank pipe
srpt_rank_out  out  RANK_WIDTH  to rank pipe
err_unknown_flow  out  1  one-cycle pulse, non-first SRPT packet hit an invalid flow entry
insert_count  out  32  inserts issued since reset, wraps at 2^32

Behaviour:
- Clock and reset: one clock, clk. rst_n is an asynchronous, active-low reset.
- Reset state: out_valid=0, insert=0, all table valid bits=0, remaining=0, insert_count=0, err_unknown_flow=0. rank_op_out, meta_out and srpt_rank_out reset to 0.
- Output stage: a single holding register (out_valid plus fields).
  - insert = out_valid & ~busy (combinational). insert is never high while busy=1.
  - s_ready = ~out_valid | ~busy (combinational). The stage refills in the same cycle it drains.
  - Accept: on s_valid & s_ready, the fields are computed combinationally from the table and registered. The table is updated on the same edge.
  - Latency: descriptor accept to insert is 1 cycle when busy=0.
  - Hold: while busy=1 with out_valid=1, the outputs are held stable and no descriptor is accepted.
- SRPT computation (s_rank_op == SRPT_OP):
  - First packet: rem_before = s_flow_size. Set valid[id]=1.
  - Non-first packet, valid[id]=1: rem_before = remaining[id].
  - Non-first packet, valid[id]=0: srpt rank = all ones. err_unknown_flow pulses on the accept edge. Table untouched.
  - Rank: srpt_rank_out = min(rem_before, 2^RANK_WIDTH-1) (saturate, no truncation).
  - Update: rem_after = rem_before - s_pkt_len, saturating at 0 (pkt_len > rem is not an error). remaining[id] = rem_after.
  - Flow end: if rem_after == 0, valid[id] is cleared.
- Non-SRPT ops: srpt_rank_out = 0, table untouched, descriptor passed through.
- Back-to-back same flow: the table is flop-based and updated on the accept edge, so the next-cycle accept sees the new value. No bubble.
- insert_count increments on each insert cycle.
- Reset mid-operation: any held descriptor is discarded and the table is cleared. No insert on the first cycle after deassertion.

Decomposition:
- Shared package: SRPT_OP and the other rank-op code constants, the saturating-subtract and saturate-to-RANK_WIDTH functions, and the flow-table entry type (valid plus remaining).
- Sub-module: srpt_flow_table, holding the register array with a combinational read port and a single write port.
- The output holding stage and counters remain in the top module.

Test Plan:
1. Reset: hold rst_n=0 while s_valid=1 and busy=0 → insert=0, s_ready=1, insert_count=0; outputs still 0 one cycle after release.
2. First packet: flow 3, size 4000, len 1500, busy=0 → next cycle insert=1 with rank 4000. Follow with non-first, len 1500 → rank 2500. Then len 1500 → rank 1000, remaining saturates to 0 and valid[3] clears.
3. Saturation: size 100000 → rank 65535. Non-first on unused flow 7 → rank 65535 and a one-cycle err_unknown_flow pulse.
4. Backpressure: busy=1 for 5 cycles with a descriptor held → insert=0, outputs stable, s_ready=0. On busy=0 → one insert, and a new descriptor is accepted in the same cycle.
5. Non-SRPT op: s_rank_op=1 with meta 0xBEEF → insert with rank 0 and meta 0xBEEF; flow-table contents unchanged.
6. Streaming: 64 back-to-back descriptors over flows 0..3 with random busy → exactly 64 inserts, insert_count=64, ranks matching the reference model, no insert while busy=1.
